fl_ckpt_ctrl: RTL and testbench

Branch-checkpoint controller for the free list. It snapshots the free-list head when a branch dispatches and hands out a branch tag. On a misprediction it drives the free list's single-cycle recovery port and squashes the mispredicted checkpoint together with every younger one. It sits between the decoder/dispatch stage, the branch-resolution path and `free_list`, and it stalls dispatch when all checkpoints are in use.

---
 rtl/fl_ckpt_ctrl_pkg.sv | 22 ++
 rtl/fl_ckpt_ctrl_prio_sel.sv | 21 ++
 rtl/fl_ckpt_ctrl.sv | 131 +++++++++++++
 tb/tb_fl_ckpt_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fl_ckpt_ctrl_pkg.sv
// Shared widths, FSM encodings and slot payload for the free-list branch-checkpoint controller.
// Optional feature macro: FL_CKPT_BYPASS_EN (same-cycle reuse of a slot freed by a correct resolve).
package fl_ckpt_ctrl_pkg;

   localparam int unsigned CKPT_NUM  = 4;
   localparam int unsigned BR_TAG_W  = 2;
   localparam int unsigned FL_HEAD_W = 5;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_RECOVER = 1'b1;

   typedef struct packed {
      logic                  busy;
      logic [FL_HEAD_W-1:0]  head;
      logic [CKPT_NUM-1:0]   older;
   } ckpt_slot_t;

   function automatic logic [CKPT_NUM-1:0] tag_onehot(input logic [BR_TAG_W-1:0] tag);
      return CKPT_NUM'(1) << tag;
   endfunction

endpackage

// File: rtl/fl_ckpt_ctrl_prio_sel.sv
// Lowest-index-free priority selector for checkpoint slot allocation.
module ckpt_prio_sel
   import fl_ckpt_ctrl_pkg::*;
(
   input  logic [CKPT_NUM-1:0] busy_i,
   output logic [BR_TAG_W-1:0] idx_o,
   output logic                found_o
);

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = 0; i < int'(CKPT_NUM); i++) begin
         if (!busy_i[i] && !found_o) begin
            idx_o   = BR_TAG_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fl_ckpt_ctrl.sv
// Branch-checkpoint controller: snapshots the free-list head per branch and drives free-list recovery.
// Optional feature macro: FL_CKPT_BYPASS_EN (slot freed by a correct resolve is reusable the same cycle).
module fl_ckpt_ctrl
   import fl_ckpt_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 br_dispatch_en_i,
   input  logic [FL_HEAD_W-1:0] fl_cur_head_i,
   input  logic                 br_resolve_en_i,
   input  logic [BR_TAG_W-1:0]  br_resolve_tag_i,
   input  logic                 br_mispredict_i,
   output logic [BR_TAG_W-1:0]  br_tag_o,
   output logic                 br_tag_vld_o,
   output logic                 br_stall_o,
   output logic                 fl_recover_en_o,
   output logic [FL_HEAD_W-1:0] fl_recover_head_o,
   output logic [CKPT_NUM-1:0]  br_kill_mask_o,
   output logic [CKPT_NUM-1:0]  ckpt_busy_o
);

   logic [0:0]           state_q, state_d;
   ckpt_slot_t           slot_q [CKPT_NUM];
   ckpt_slot_t           slot_d [CKPT_NUM];
   logic [FL_HEAD_W-1:0] rec_head_q, rec_head_d;
   logic [CKPT_NUM-1:0]  kill_q, kill_d;

   logic [CKPT_NUM-1:0]  busy_vec_c;
   logic [CKPT_NUM-1:0]  res_oh_c;
   logic                 res_hit_c;
   logic                 mp_vld_c;
   logic [CKPT_NUM-1:0]  free_c;
   logic [CKPT_NUM-1:0]  kill_c;
   logic [CKPT_NUM-1:0]  alloc_busy_c;
   logic [CKPT_NUM-1:0]  clear_c;
   logic [BR_TAG_W-1:0]  alloc_idx_c;
   logic                 alloc_found_c;

   // Resolve decode; resolves are ignored while recovering or when the tag is not live.
   always_comb begin
      for (int i = 0; i < int'(CKPT_NUM); i++) begin
         busy_vec_c[i] = slot_q[i].busy;
      end
      res_oh_c  = tag_onehot(br_resolve_tag_i);
      res_hit_c = (state_q == ST_IDLE) && br_resolve_en_i && ((busy_vec_c & res_oh_c) != '0);
      mp_vld_c  = res_hit_c && br_mispredict_i;
      free_c    = (res_hit_c && !br_mispredict_i) ? res_oh_c : '0;
      kill_c    = res_oh_c;
      for (int i = 0; i < int'(CKPT_NUM); i++) begin
         if (slot_q[i].busy && ((slot_q[i].older & res_oh_c) != '0)) begin
            kill_c[i] = 1'b1;
         end
      end
      clear_c = mp_vld_c ? kill_c : free_c;
   end

`ifdef FL_CKPT_BYPASS_EN
   assign alloc_busy_c = busy_vec_c & ~free_c;
`else
   assign alloc_busy_c = busy_vec_c;
`endif

   ckpt_prio_sel u_prio_sel (
      .busy_i  (alloc_busy_c),
      .idx_o   (alloc_idx_c),
      .found_o (alloc_found_c)
   );

   assign br_tag_o     = alloc_idx_c;
   assign br_stall_o   = !alloc_found_c || (state_q == ST_RECOVER);
   assign br_tag_vld_o = br_dispatch_en_i && !br_stall_o && !mp_vld_c;

   // Next-state: FSM, recovery payload, slot clear then allocate.
   always_comb begin
      state_d    = state_q;
      rec_head_d = '0;
      kill_d     = '0;
      for (int i = 0; i < int'(CKPT_NUM); i++) begin
         slot_d[i] = slot_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            if (mp_vld_c) begin
               state_d    = ST_RECOVER;
               rec_head_d = slot_q[br_resolve_tag_i].head;
               kill_d     = kill_c;
            end
         end
         ST_RECOVER: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      for (int i = 0; i < int'(CKPT_NUM); i++) begin
         slot_d[i].older = slot_q[i].older & ~clear_c;
         if (clear_c[i]) begin
            slot_d[i].busy  = 1'b0;
            slot_d[i].older = '0;
         end
         if (br_tag_vld_o && (BR_TAG_W'(i) == alloc_idx_c)) begin
            slot_d[i].busy  = 1'b1;
            slot_d[i].head  = fl_cur_head_i;
            slot_d[i].older = busy_vec_c & ~free_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rec_head_q <= '0;
         kill_q     <= '0;
         for (int i = 0; i < int'(CKPT_NUM); i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         rec_head_q <= rec_head_d;
         kill_q     <= kill_d;
         for (int i = 0; i < int'(CKPT_NUM); i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign fl_recover_en_o   = (state_q == ST_RECOVER);
   assign fl_recover_head_o = rec_head_q;
   assign br_kill_mask_o    = kill_q;
   assign ckpt_busy_o       = busy_vec_c;

endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// Self-checking bench for fl_ckpt_ctrl: directed scenarios plus random traffic against an age-ordered reference model.
module tb_fl_ckpt_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       disp;
   logic [4:0] head_in;
   logic       res_en;
   logic [1:0] res_tag;
   logic       mp;

   logic [1:0] br_tag_o;
   logic       br_tag_vld_o;
   logic       br_stall_o;
   logic       fl_recover_en_o;
   logic [4:0] fl_recover_head_o;
   logic [3:0] br_kill_mask_o;
   logic [3:0] ckpt_busy_o;

   int n_chk = 0;
   int n_err = 0;

   // reference model: each live checkpoint carries an allocation sequence number
   bit m_busy [4];
   int m_head [4];
   int m_seq  [4];
   int seq_cnt;
   bit m_rec;
   int m_rec_head;
   int m_kill;
   bit model_ok = 1'b0;

   bit e_mp, e_free, e_stall, e_vld;
   int e_tag;

   fl_ckpt_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .br_dispatch_en_i  (disp),
      .fl_cur_head_i     (head_in),
      .br_resolve_en_i   (res_en),
      .br_resolve_tag_i  (res_tag),
      .br_mispredict_i   (mp),
      .br_tag_o          (br_tag_o),
      .br_tag_vld_o      (br_tag_vld_o),
      .br_stall_o        (br_stall_o),
      .fl_recover_en_o   (fl_recover_en_o),
      .fl_recover_head_o (fl_recover_head_o),
      .br_kill_mask_o    (br_kill_mask_o),
      .ckpt_busy_o       (ckpt_busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int busy_vec();
      int v = 0;
      for (int i = 0; i < 4; i++) if (m_busy[i]) v |= (1 << i);
      return v;
   endfunction

   task automatic model_eval();
      bit avail [4];
      bit full;
      e_mp   = !m_rec && res_en && mp && m_busy[res_tag];
      e_free = !m_rec && res_en && !mp && m_busy[res_tag];
      full   = 1'b1;
      e_tag  = 0;
      for (int i = 3; i >= 0; i--) begin
         avail[i] = !m_busy[i];
`ifdef FL_CKPT_BYPASS_EN
         if (e_free && (i == int'(res_tag))) avail[i] = 1'b1;
`endif
         if (avail[i]) begin
            full  = 1'b0;
            e_tag = i;
         end
      end
      e_stall = m_rec || full;
      e_vld   = disp && !e_stall && !e_mp;
      if (model_ok) begin
         chk("stall", 32'(br_stall_o), 32'(e_stall));
         chk("tag_vld", 32'(br_tag_vld_o), 32'(e_vld));
         if (!e_stall) chk("tag", 32'(br_tag_o), 32'(e_tag));
         chk("rec_en", 32'(fl_recover_en_o), 32'(m_rec));
         chk("rec_head", 32'(fl_recover_head_o), 32'(m_rec_head));
         chk("kill_mask", 32'(br_kill_mask_o), 32'(m_kill));
         chk("busy", 32'(ckpt_busy_o), 32'(busy_vec()));
      end
   endtask

   task automatic model_update();
      int t;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_busy[i] = 0; m_head[i] = 0; m_seq[i] = 0;
         end
         seq_cnt = 0; m_rec = 0; m_rec_head = 0; m_kill = 0;
         model_ok = 1'b1;
         return;
      end
      t = int'(res_tag);
      m_rec = 0; m_rec_head = 0; m_kill = 0;
      if (e_mp) begin
         m_kill = 1 << t;
         for (int i = 0; i < 4; i++)
            if (m_busy[i] && m_seq[i] > m_seq[t]) m_kill |= (1 << i);
         m_rec      = 1;
         m_rec_head = m_head[t];
         for (int i = 0; i < 4; i++) if (m_kill[i]) m_busy[i] = 0;
      end else if (e_free) begin
         m_busy[t] = 0;
      end
      if (e_vld) begin
         m_busy[e_tag] = 1;
         m_head[e_tag] = int'(head_in);
         m_seq[e_tag]  = ++seq_cnt;
      end
   endtask

   // drive inputs mid-cycle, then compare everything against the model
   task automatic apply(input bit d, input int h, input bit re, input int rt, input bit m, input bit r);
      @(negedge clk);
      disp = d; head_in = 5'(h); res_en = re; res_tag = 2'(rt); mp = m; rst = r;
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      disp = 0; head_in = 0; res_en = 0; res_tag = 0; mp = 0; rst = 1;
      apply(0, 0, 0, 0, 0, 1); tick();

      apply(0, 0, 0, 0, 0, 0);
      chk("rst_tag", 32'(br_tag_o), 0);
      chk("rst_vld", 32'(br_tag_vld_o), 0);
      chk("rst_stall", 32'(br_stall_o), 0);
      chk("rst_busy", 32'(ckpt_busy_o), 0);
      chk("rst_rec_en", 32'(fl_recover_en_o), 0);
      tick();

      for (int i = 0; i < 4; i++) begin
         apply(1, 3 + 2 * i, 0, 0, 0, 0);
         chk("fill_tag", 32'(br_tag_o), 32'(i));
         chk("fill_vld", 32'(br_tag_vld_o), 1);
         tick();
      end
      apply(1, 11, 0, 0, 0, 0);
      chk("full_busy", 32'(ckpt_busy_o), 32'hF);
      chk("full_stall", 32'(br_stall_o), 1);
      chk("full_vld", 32'(br_tag_vld_o), 0);
      tick();

      apply(0, 0, 1, 1, 1, 0); tick();
      apply(0, 0, 0, 0, 0, 0);
      chk("mp1_rec_en", 32'(fl_recover_en_o), 1);
      chk("mp1_head", 32'(fl_recover_head_o), 5);
      chk("mp1_kill", 32'(br_kill_mask_o), 32'hE);
      tick();
      apply(0, 0, 0, 0, 0, 0);
      chk("mp1_busy_after", 32'(ckpt_busy_o), 32'h1);
      chk("mp1_stall_after", 32'(br_stall_o), 0);
      tick();

      apply(1, 12, 0, 0, 0, 0);
      chk("realloc_tag", 32'(br_tag_o), 1);
      tick();
      apply(0, 0, 1, 0, 0, 0); tick();
      apply(1, 13, 1, 1, 1, 0);
      chk("res_busy", 32'(ckpt_busy_o), 32'h2);
      chk("mp_disp_vld", 32'(br_tag_vld_o), 0);
      tick();
      apply(0, 0, 0, 0, 0, 0);
      chk("mp2_kill", 32'(br_kill_mask_o), 32'h2);
      chk("mp2_head", 32'(fl_recover_head_o), 12);
      tick();
      apply(0, 0, 0, 0, 0, 0);
      chk("mp2_busy_after", 32'(ckpt_busy_o), 0);
      tick();

      for (int i = 0; i < 4; i++) begin
         apply(1, 20 + i, 0, 0, 0, 0); tick();
      end
      apply(1, 24, 1, 2, 0, 0);
`ifdef FL_CKPT_BYPASS_EN
      chk("bypass_tag", 32'(br_tag_o), 2);
      chk("bypass_vld", 32'(br_tag_vld_o), 1);
`else
      chk("nobypass_stall", 32'(br_stall_o), 1);
      chk("nobypass_vld", 32'(br_tag_vld_o), 0);
`endif
      tick();

      apply(0, 0, 1, 0, 1, 0); tick();
      apply(0, 0, 0, 0, 0, 1);
      chk("rst_in_rec_en", 32'(fl_recover_en_o), 1);
      tick();
      apply(0, 0, 0, 0, 0, 0);
      chk("post_rst_rec_en", 32'(fl_recover_en_o), 0);
      chk("post_rst_kill", 32'(br_kill_mask_o), 0);
      chk("post_rst_head", 32'(fl_recover_head_o), 0);
      chk("post_rst_busy", 32'(ckpt_busy_o), 0);
      chk("post_rst_stall", 32'(br_stall_o), 0);
      tick();

      for (int n = 0; n < 2000; n++) begin
         bit d, re, m, r;
         d  = ($urandom_range(99) < 60);
         re = ($urandom_range(99) < 40);
         m  = ($urandom_range(99) < 25);
         r  = ($urandom_range(999) < 8);
         apply(d, int'($urandom_range(31)), re, int'($urandom_range(3)), m, r);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
